// File: rtl/vram_sched.sv
// Single-port VRAM scheduler: video reads win outright, the other requesters
// (regs, blit, draw) share the remaining cycles in rotation with registered acks.
module vram_sched #(
    parameter bit EN_BLIT = 1'b1,
    parameter bit EN_DRAW = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        vgen_sel_i,
    input  logic [15:0] vgen_addr_i,
    input  logic        regs_sel_i,
    input  logic        regs_wr_i,
    input  logic [3:0]  regs_wr_mask_i,
    input  logic [15:0] regs_addr_i,
    input  logic [15:0] regs_data_i,
    input  logic        blit_sel_i,
    input  logic        blit_wr_i,
    input  logic [3:0]  blit_wr_mask_i,
    input  logic [15:0] blit_addr_i,
    input  logic [15:0] blit_data_i,
    input  logic        draw_sel_i,
    input  logic        draw_wr_i,
    input  logic [3:0]  draw_wr_mask_i,
    input  logic [15:0] draw_addr_i,
    input  logic [15:0] draw_data_i,
    output logic        regs_ack_o,
    output logic        blit_ack_o,
    output logic        draw_ack_o,
    output logic        mem_sel_o,
    output logic        mem_wr_o,
    output logic [3:0]  mem_wr_mask_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_data_o,
    input  logic [15:0] mem_data_i,
    output logic [15:0] rd_data_o
);

    typedef enum logic [1:0] {
        RQ_REGS = 2'd0,
        RQ_BLIT = 2'd1,
        RQ_DRAW = 2'd2
    } req_e;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_VGEN,
        GNT_REGS,
        GNT_BLIT,
        GNT_DRAW
    } grant_e;

    req_e       rr_last_q, rr_last_d;
    logic [2:0] ack_q, ack_d;
    logic [2:0] elig;
    req_e       pick;
    logic       pick_vld;
    grant_e     grant;

    // A requester being acked this cycle is locked out, so its held sel is not a new request.
    assign elig[0] = regs_sel_i && !ack_q[0];
    assign elig[1] = EN_BLIT && blit_sel_i && !ack_q[1];
    assign elig[2] = EN_DRAW && draw_sel_i && !ack_q[2];

    always_comb begin
        pick     = RQ_REGS;
        pick_vld = |elig;
        case (rr_last_q)
            RQ_REGS: begin
                if (elig[1])      pick = RQ_BLIT;
                else if (elig[2]) pick = RQ_DRAW;
                else              pick = RQ_REGS;
            end
            RQ_BLIT: begin
                if (elig[2])      pick = RQ_DRAW;
                else if (elig[0]) pick = RQ_REGS;
                else              pick = RQ_BLIT;
            end
            default: begin
                if (elig[0])      pick = RQ_REGS;
                else if (elig[1]) pick = RQ_BLIT;
                else              pick = RQ_DRAW;
            end
        endcase
    end

    always_comb begin
        grant = GNT_NONE;
        if (vgen_sel_i) begin
            grant = GNT_VGEN;
        end else if (pick_vld) begin
            case (pick)
                RQ_REGS: grant = GNT_REGS;
                RQ_BLIT: grant = GNT_BLIT;
                default: grant = GNT_DRAW;
            endcase
        end
    end

    // Video grants leave the rotation pointer untouched.
    always_comb begin
        ack_d     = 3'b000;
        rr_last_d = rr_last_q;
        case (grant)
            GNT_REGS: begin ack_d = 3'b001; rr_last_d = RQ_REGS; end
            GNT_BLIT: begin ack_d = 3'b010; rr_last_d = RQ_BLIT; end
            GNT_DRAW: begin ack_d = 3'b100; rr_last_d = RQ_DRAW; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_last_q <= RQ_DRAW;
            ack_q     <= 3'b000;
        end else begin
            rr_last_q <= rr_last_d;
            ack_q     <= ack_d;
        end
    end

    // The strobes are forced idle while reset is held, whatever the sel inputs do.
    always_comb begin
        mem_sel_o     = 1'b0;
        mem_wr_o      = 1'b0;
        mem_wr_mask_o = 4'b0000;
        mem_addr_o    = 16'h0000;
        mem_data_o    = 16'h0000;
        if (reset_n_i) begin
            case (grant)
                GNT_VGEN: begin
                    mem_sel_o  = 1'b1;
                    mem_addr_o = vgen_addr_i;
                end
                GNT_REGS: begin
                    mem_sel_o     = 1'b1;
                    mem_wr_o      = regs_wr_i;
                    mem_wr_mask_o = regs_wr_mask_i;
                    mem_addr_o    = regs_addr_i;
                    mem_data_o    = regs_data_i;
                end
                GNT_BLIT: begin
                    mem_sel_o     = 1'b1;
                    mem_wr_o      = blit_wr_i;
                    mem_wr_mask_o = blit_wr_mask_i;
                    mem_addr_o    = blit_addr_i;
                    mem_data_o    = blit_data_i;
                end
                GNT_DRAW: begin
                    mem_sel_o     = 1'b1;
                    mem_wr_o      = draw_wr_i;
                    mem_wr_mask_o = draw_wr_mask_i;
                    mem_addr_o    = draw_addr_i;
                    mem_data_o    = draw_data_i;
                end
                default: ;
            endcase
        end
    end

    assign regs_ack_o = ack_q[0];
    assign blit_ack_o = EN_BLIT && ack_q[1];
    assign draw_ack_o = EN_DRAW && ack_q[2];
    assign rd_data_o  = mem_data_i;

endmodule

// File: tb/tb_vram_sched.sv
// Bench for vram_sched: one instance with all requesters enabled, one with blit/draw
// disabled, sharing stimulus; a VRAM model returns addr ^ KEY one cycle after each read.
module tb_vram_sched;
    localparam logic [15:0] KEY = 16'hB791;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        vgen_sel;
    logic [15:0] vgen_addr;
    logic        regs_sel, regs_wr, blit_sel, blit_wr, draw_sel, draw_wr;
    logic [3:0]  regs_mask, blit_mask, draw_mask;
    logic [15:0] regs_addr, regs_data, blit_addr, blit_data, draw_addr, draw_data;
    logic [15:0] mem_data;

    logic        a_regs_ack, a_blit_ack, a_draw_ack, a_mem_sel, a_mem_wr;
    logic [3:0]  a_mem_mask;
    logic [15:0] a_mem_addr, a_mem_data, a_rd_data;
    logic        b_regs_ack, b_blit_ack, b_draw_ack, b_mem_sel, b_mem_wr;
    logic [3:0]  b_mem_mask;
    logic [15:0] b_mem_addr, b_mem_data, b_rd_data;

    int n_checks = 0;
    int n_pass   = 0;
    // Entry: {wr, requester id (0 regs, 1 blit, 2 draw), expected read data}
    logic [18:0] exp_q[$];

    vram_sched #(.EN_BLIT(1'b1), .EN_DRAW(1'b1)) dut_a (
        .clk(clk), .reset_n_i(reset_n),
        .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr),
        .regs_sel_i(regs_sel), .regs_wr_i(regs_wr), .regs_wr_mask_i(regs_mask),
        .regs_addr_i(regs_addr), .regs_data_i(regs_data),
        .blit_sel_i(blit_sel), .blit_wr_i(blit_wr), .blit_wr_mask_i(blit_mask),
        .blit_addr_i(blit_addr), .blit_data_i(blit_data),
        .draw_sel_i(draw_sel), .draw_wr_i(draw_wr), .draw_wr_mask_i(draw_mask),
        .draw_addr_i(draw_addr), .draw_data_i(draw_data),
        .regs_ack_o(a_regs_ack), .blit_ack_o(a_blit_ack), .draw_ack_o(a_draw_ack),
        .mem_sel_o(a_mem_sel), .mem_wr_o(a_mem_wr), .mem_wr_mask_o(a_mem_mask),
        .mem_addr_o(a_mem_addr), .mem_data_o(a_mem_data), .mem_data_i(mem_data),
        .rd_data_o(a_rd_data)
    );

    vram_sched #(.EN_BLIT(1'b0), .EN_DRAW(1'b0)) dut_b (
        .clk(clk), .reset_n_i(reset_n),
        .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr),
        .regs_sel_i(regs_sel), .regs_wr_i(regs_wr), .regs_wr_mask_i(regs_mask),
        .regs_addr_i(regs_addr), .regs_data_i(regs_data),
        .blit_sel_i(blit_sel), .blit_wr_i(blit_wr), .blit_wr_mask_i(blit_mask),
        .blit_addr_i(blit_addr), .blit_data_i(blit_data),
        .draw_sel_i(draw_sel), .draw_wr_i(draw_wr), .draw_wr_mask_i(draw_mask),
        .draw_addr_i(draw_addr), .draw_data_i(draw_data),
        .regs_ack_o(b_regs_ack), .blit_ack_o(b_blit_ack), .draw_ack_o(b_draw_ack),
        .mem_sel_o(b_mem_sel), .mem_wr_o(b_mem_wr), .mem_wr_mask_o(b_mem_mask),
        .mem_addr_o(b_mem_addr), .mem_data_o(b_mem_data), .mem_data_i(mem_data),
        .rd_data_o(b_rd_data)
    );

    // VRAM model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        mem_data <= (a_mem_sel && !a_mem_wr) ? (a_mem_addr ^ KEY) : 16'h0000;
    end

    // Scoreboard: every ack on the full instance pops one expected access.
    always @(negedge clk) begin
        logic [2:0]  acks;
        logic [2:0]  exp_acks;
        logic [18:0] e;
        acks = {a_draw_ack, a_blit_ack, a_regs_ack};
        if (acks !== 3'b000) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_ack: acks=%b, required none at %0t", acks, $time);
            end else begin
                e        = exp_q.pop_front();
                exp_acks = 3'b001 << e[17:16];
                if (acks !== exp_acks || (!e[18] && a_rd_data !== e[15:0]))
                    $display("FAIL sb_ack: acks=%b rd=%h, required acks=%b rd=%h at %0t",
                             acks, a_rd_data, exp_acks, e[15:0], $time);
                else
                    n_pass++;
            end
        end
        n_checks++;
        if ({b_blit_ack, b_draw_ack} !== 2'b00)
            $display("FAIL disabled_ack: blit=%b draw=%b, required 0 at %0t", b_blit_ack, b_draw_ack, $time);
        else
            n_pass++;
    end

    task automatic clear_inputs();
        vgen_sel = 0; vgen_addr = 0;
        regs_sel = 0; regs_wr = 0; regs_mask = 0; regs_addr = 0; regs_data = 0;
        blit_sel = 0; blit_wr = 0; blit_mask = 0; blit_addr = 0; blit_data = 0;
        draw_sel = 0; draw_wr = 0; draw_mask = 0; draw_addr = 0; draw_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        clear_inputs();
        reset_n = 0;
        step();
        reset_n = 1;
    endtask

    task automatic test_reset();
        vgen_sel = 1; regs_sel = 1; blit_sel = 1; draw_sel = 1;
        vgen_addr = 16'(($urandom_range(0, 65535)));
        regs_addr = 16'h1111; blit_addr = 16'h2222; draw_addr = 16'h3333;
        step();
        @(negedge clk);
        n_checks++;
        if ({a_mem_sel, b_mem_sel, a_regs_ack, a_blit_ack, a_draw_ack, b_regs_ack} !== 6'b0 || a_mem_addr !== 16'h0)
            $display("FAIL reset_idle: sel=%b/%b acks=%b%b%b addr=%h, required all 0",
                     a_mem_sel, b_mem_sel, a_regs_ack, a_blit_ack, a_draw_ack, a_mem_addr);
        else n_pass++;
        step();
        clear_inputs();
        regs_sel = 1; regs_addr = 16'h1234;
        reset_n = 1;
        exp_q.push_back({1'b0, 2'd0, 16'h1234 ^ KEY});
        @(negedge clk);
        n_checks++;
        if ({a_mem_sel, a_mem_wr} !== 2'b10 || a_mem_addr !== 16'h1234)
            $display("FAIL reset_first_grant: sel=%b wr=%b addr=%h, required sel=1 wr=0 addr=1234",
                     a_mem_sel, a_mem_wr, a_mem_addr);
        else n_pass++;
        step();
        regs_sel = 0;
        @(negedge clk);
        n_checks++;
        if (a_regs_ack !== 1'b1 || a_rd_data !== 16'hA5A5)
            $display("FAIL reset_first_ack: ack=%b rd=%h, required ack=1 rd=a5a5", a_regs_ack, a_rd_data);
        else n_pass++;
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL reset_drain: %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_vgen_priority();
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            if (c < 3) begin
                vgen_sel = 1; vgen_addr = 16'h8000 + 16'(c);
                regs_sel = 1; regs_addr = 16'h2222;
            end else if (c == 3) begin
                vgen_sel = 0;
                exp_q.push_back({1'b0, 2'd0, 16'h2222 ^ KEY});
            end else begin
                regs_sel = 0;
            end
            @(negedge clk);
            n_checks++;
            if (c < 3 && ({a_mem_sel, a_mem_wr} !== 2'b10 || a_mem_addr !== 16'h8000 + 16'(c)))
                $display("FAIL vgen_win: cycle %0d sel=%b wr=%b addr=%h, required 1/0/%h",
                         c, a_mem_sel, a_mem_wr, a_mem_addr, 16'h8000 + 16'(c));
            else if (c == 3 && (a_mem_addr !== 16'h2222 || a_regs_ack !== 1'b0))
                $display("FAIL vgen_regs_grant: addr=%h ack=%b, required 2222/0", a_mem_addr, a_regs_ack);
            else if (c >= 4 && a_regs_ack !== (c == 4))
                $display("FAIL vgen_regs_ack: cycle %0d ack=%b, required %b", c, a_regs_ack, c == 4);
            else n_pass++;
        end
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL vgen_drain: %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_rotation();
        logic [15:0] addrs[3];
        apply_reset();
        addrs[0] = {4'h1, 12'($urandom_range(0, 4095))};
        addrs[1] = {4'h2, 12'($urandom_range(0, 4095))};
        addrs[2] = {4'h3, 12'($urandom_range(0, 4095))};
        for (int c = 0; c < 9; c++) begin
            step();
            if (c == 0) begin
                regs_sel = 1; regs_addr = addrs[0];
                blit_sel = 1; blit_addr = addrs[1];
                draw_sel = 1; draw_addr = addrs[2];
            end
            exp_q.push_back({1'b0, 2'(c % 3), addrs[c % 3] ^ KEY});
            @(negedge clk);
            n_checks++;
            if (a_mem_sel !== 1'b1 || a_mem_addr !== addrs[c % 3])
                $display("FAIL rotation_grant: cycle %0d sel=%b addr=%h, required 1/%h",
                         c, a_mem_sel, a_mem_addr, addrs[c % 3]);
            else n_pass++;
            n_checks++;
            if (b_mem_sel !== (c % 2 == 0))
                $display("FAIL rotation_disabled_skip: cycle %0d sel=%b, required %b", c, b_mem_sel, c % 2 == 0);
            else n_pass++;
        end
        step();
        clear_inputs();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL rotation_drain: %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_write();
        apply_reset();
        step();
        blit_sel = 1; blit_wr = 1; blit_addr = 16'h0100; blit_data = 16'hBEEF; blit_mask = 4'b0011;
        exp_q.push_back({1'b1, 2'd1, 16'h0000});
        @(negedge clk);
        n_checks++;
        if ({a_mem_sel, a_mem_wr, a_mem_mask} !== 6'b11_0011 || a_mem_data !== 16'hBEEF || a_mem_addr !== 16'h0100)
            $display("FAIL write_blit: sel=%b wr=%b mask=%b data=%h addr=%h, required 1/1/0011/beef/0100",
                     a_mem_sel, a_mem_wr, a_mem_mask, a_mem_data, a_mem_addr);
        else n_pass++;
        n_checks++;
        if (b_mem_sel !== 1'b0)
            $display("FAIL write_blit_disabled: sel=%b, required 0", b_mem_sel);
        else n_pass++;
        step();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (a_blit_ack !== 1'b1 || b_mem_sel !== 1'b0)
            $display("FAIL write_blit_ack: ack=%b disabled_sel=%b, required 1/0", a_blit_ack, b_mem_sel);
        else n_pass++;
        step();
        regs_sel = 1; regs_wr = 1; regs_mask = 4'b0000; regs_addr = 16'h0042; regs_data = 16'h5555;
        exp_q.push_back({1'b1, 2'd0, 16'h0000});
        @(negedge clk);
        n_checks++;
        if ({a_mem_sel, a_mem_wr, a_mem_mask, b_mem_sel} !== 7'b11_0000_1 || a_mem_addr !== 16'h0042)
            $display("FAIL write_nop_mask: sel=%b wr=%b mask=%b b_sel=%b addr=%h, required 1/1/0000/1/0042",
                     a_mem_sel, a_mem_wr, a_mem_mask, b_mem_sel, a_mem_addr);
        else n_pass++;
        step();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (a_regs_ack !== 1'b1 || b_regs_ack !== 1'b1)
            $display("FAIL write_nop_ack: ack=%b/%b, required 1/1", a_regs_ack, b_regs_ack);
        else n_pass++;
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL write_drain: %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_lockout();
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin
                regs_sel = 1; regs_addr = 16'h4444;
            end
            if (c % 2 == 0) exp_q.push_back({1'b0, 2'd0, 16'h4444 ^ KEY});
            @(negedge clk);
            n_checks++;
            if (a_mem_sel !== (c % 2 == 0) || a_regs_ack !== (c % 2 == 1))
                $display("FAIL lockout: cycle %0d sel=%b ack=%b, required %b/%b",
                         c, a_mem_sel, a_regs_ack, c % 2 == 0, c % 2 == 1);
            else n_pass++;
        end
        step();
        clear_inputs();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL lockout_drain: %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_vgen_keeps_rr();
        apply_reset();
        step();
        vgen_sel = 1; vgen_addr = 16'hC0DE;
        regs_sel = 1; regs_addr = 16'h0A0A;
        blit_sel = 1; blit_addr = 16'h0B0B;
        @(negedge clk);
        n_checks++;
        if (a_mem_addr !== 16'hC0DE)
            $display("FAIL vgen_rr_vgen: addr=%h, required c0de", a_mem_addr);
        else n_pass++;
        step();
        vgen_sel = 0;
        exp_q.push_back({1'b0, 2'd0, 16'h0A0A ^ KEY});
        @(negedge clk);
        n_checks++;
        if (a_mem_addr !== 16'h0A0A)
            $display("FAIL vgen_rr_regs_first: addr=%h, required 0a0a", a_mem_addr);
        else n_pass++;
        step();
        regs_sel = 0;
        exp_q.push_back({1'b0, 2'd1, 16'h0B0B ^ KEY});
        @(negedge clk);
        n_checks++;
        if (a_mem_addr !== 16'h0B0B)
            $display("FAIL vgen_rr_blit_next: addr=%h, required 0b0b", a_mem_addr);
        else n_pass++;
        step();
        blit_sel = 0;
        @(negedge clk);
        n_checks++;
        if ({a_mem_sel, a_mem_wr, a_mem_mask} !== 6'b0 || a_mem_addr !== 16'h0 || a_mem_data !== 16'h0)
            $display("FAIL none_outputs: sel=%b wr=%b mask=%b addr=%h data=%h, required all 0",
                     a_mem_sel, a_mem_wr, a_mem_mask, a_mem_addr, a_mem_data);
        else n_pass++;
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL vgen_rr_drain: %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        step();
        regs_sel = 1; regs_addr = 16'h3333;
        @(negedge clk);
        n_checks++;
        if (a_mem_sel !== 1'b1 || a_mem_addr !== 16'h3333)
            $display("FAIL midreset_grant: sel=%b addr=%h, required 1/3333", a_mem_sel, a_mem_addr);
        else n_pass++;
        #1 reset_n = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (a_regs_ack !== 1'b0 || a_mem_sel !== 1'b0)
                $display("FAIL midreset_no_ack: cycle %0d ack=%b sel=%b, required 0/0", c, a_regs_ack, a_mem_sel);
            else n_pass++;
        end
        step();
        regs_sel = 1; regs_addr = 16'h3333;
        blit_sel = 1; blit_addr = 16'h7777;
        reset_n = 1;
        exp_q.push_back({1'b0, 2'd0, 16'h3333 ^ KEY});
        @(negedge clk);
        n_checks++;
        if (a_mem_addr !== 16'h3333)
            $display("FAIL midreset_regs_first: addr=%h, required 3333", a_mem_addr);
        else n_pass++;
        step();
        regs_sel = 0;
        exp_q.push_back({1'b0, 2'd1, 16'h7777 ^ KEY});
        @(negedge clk);
        n_checks++;
        if (a_mem_addr !== 16'h7777)
            $display("FAIL midreset_blit_next: addr=%h, required 7777", a_mem_addr);
        else n_pass++;
        step();
        blit_sel = 0;
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL midreset_drain: %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        test_reset();
        test_vgen_priority();
        test_rotation();
        test_write();
        test_lockout();
        test_vgen_keeps_rr();
        test_reset_mid_access();
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
